// File: rtl/paralleltoserial.sv
// paralleltoserial: byte-to-serial transmitter, sending end of the link that
// serialtopar receives.
//
// After reset it sends SYNC_COUNT COM symbols so the receiver can lock, then
// accepts one byte per 8-cycle symbol through a valid/ready handshake and
// shifts it out MSB-first. Any symbol slot without a byte is filled with COM.
//
// Parameters:
//   COM        idle/sync symbol (default 8'hBC)
//   SYNC_COUNT number of forced COM symbols after reset, legal range 2..15
//
// Ports:
//   clk_8f      bit clock, all state changes on the rising edge
//   reset_L     asynchronous active-low reset
//   data_in     byte to send, sampled only on a transfer edge
//   valid_in    data_in holds a byte to send
//   ready_out   block accepts a byte on this cycle's closing edge
//   data_out    serial bit stream, MSB of each symbol first
//   active_out  preamble finished, the link carries data
module paralleltoserial #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter int         SYNC_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active_out
);

  typedef enum logic {
    SYNC,
    ACTIVE
  } state_t;

  // sc counts finished preamble symbols; the last one is recognised one
  // symbol early so the state flips as the final forced COM is loaded.
  localparam logic [3:0] SC_LAST = 4'(SYNC_COUNT - 2);

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] cnt;
  logic [3:0] sc;

  assign data_out = shreg[7];

  // ready_out and active_out are flops kept equal to their decodes
  // (ACTIVE && cnt == 7, and ACTIVE) by computing them from next-state values.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      shreg      <= COM;
      cnt        <= 3'd0;
      sc         <= 4'd0;
      state      <= SYNC;
      ready_out  <= 1'b0;
      active_out <= 1'b0;
    end else if (cnt != 3'd7) begin
      shreg     <= {shreg[6:0], 1'b0};
      cnt       <= cnt + 3'd1;
      ready_out <= (state == ACTIVE) && (cnt == 3'd6);
    end else begin
      cnt       <= 3'd0;
      ready_out <= 1'b0;
      case (state)
        SYNC: begin
          shreg <= COM;
          if (sc == SC_LAST) begin
            state      <= ACTIVE;
            active_out <= 1'b1;
          end else begin
            sc <= sc + 4'd1;
          end
        end
        ACTIVE: begin
          if (valid_in && ready_out) begin
            shreg <= data_in;
          end else begin
            shreg <= COM;
          end
        end
        default: begin
          shreg <= COM;
          state <= SYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_paralleltoserial.sv
// tb_paralleltoserial: self-checking bench for paralleltoserial.
//
// A default build (SYNC_COUNT=4) is driven from per-cycle vector tables built
// from the expected symbol sequence; a second build with SYNC_COUNT=2 shares
// the same inputs and is checked bit by bit against a symbol-level model.
module tb_paralleltoserial;

  localparam logic [7:0] COM = 8'hBC;

  logic       clk_8f = 1'b0;
  logic       reset_L;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       active_out;
  logic       ready2;
  logic       dout2;
  logic       active2;

  int n_checks = 0;
  int n_bad    = 0;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       exp_dout;
    logic       exp_ready;
    logic       exp_active;
  } vec_t;

  vec_t       vecs [64];
  logic [7:0] syms [8];

  paralleltoserial #(.COM(COM), .SYNC_COUNT(4)) dut (
    .clk_8f    (clk_8f),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .active_out(active_out)
  );

  paralleltoserial #(.COM(COM), .SYNC_COUNT(2)) dut2 (
    .clk_8f    (clk_8f),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready2),
    .data_out  (dout2),
    .active_out(active2)
  );

  always #5 clk_8f = ~clk_8f;

  task automatic checkOutput(input string name, input int cyc, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    valid_in = valid;
    data_in  = data;
  endtask

  // Expected outputs for the default build: symbol c/8 sent MSB first,
  // active from cycle 24, ready on the last cycle of each symbol from 31.
  task automatic fillExpect(input int n);
    for (int c = 0; c < n; c++) begin
      vecs[c].exp_dout   = syms[c / 8][7 - (c % 8)];
      vecs[c].exp_ready  = (c >= 31) && (c % 8 == 7);
      vecs[c].exp_active = (c >= 24);
    end
  endtask

  // Called at cycle 0 (just after reset release); returns at cycle n.
  task automatic runVectors(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      checkOutput({name, "_dout"},   c, data_out,   vecs[c].exp_dout);
      checkOutput({name, "_ready"},  c, ready_out,  vecs[c].exp_ready);
      checkOutput({name, "_active"}, c, active_out, vecs[c].exp_active);
      applyStimulus(vecs[c].valid, vecs[c].data);
      @(posedge clk_8f);
      #1;
    end
  endtask

  // Holds reset for 5 cycles with valid_in high, then releases it; the
  // moment of release is cycle 0.
  task automatic doReset();
    applyStimulus(1'b1, 8'h66);
    reset_L = 1'b0;
    repeat (5) begin
      @(posedge clk_8f);
      #1;
      checkOutput("rst_dout",   -1, data_out,   1'b1);
      checkOutput("rst_ready",  -1, ready_out,  1'b0);
      checkOutput("rst_active", -1, active_out, 1'b0);
    end
    reset_L = 1'b1;
  endtask

  // Symbol-level reference for the SYNC_COUNT=2 build.
  int         m_cycle = 0;
  logic [7:0] m_sym   = COM;

  always @(posedge clk_8f) begin
    if (reset_L === 1'b1) begin
      if (m_cycle % 8 == 7) begin
        m_sym = (m_cycle >= 15 && valid_in) ? data_in : COM;
      end
      m_cycle++;
    end
  end

  always @(negedge clk_8f) begin
    if (reset_L !== 1'b1) begin
      m_cycle = 0;
      m_sym   = COM;
      checkOutput("sc2_rst_dout", -1, dout2, 1'b1);
    end else begin
      checkOutput("sc2_dout",   m_cycle, dout2,   m_sym[7 - (m_cycle % 8)]);
      checkOutput("sc2_ready",  m_cycle, ready2,  (m_cycle >= 15) && (m_cycle % 8 == 7));
      checkOutput("sc2_active", m_cycle, active2, (m_cycle >= 8));
    end
  end

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;

    // Preamble followed by a single A5 byte, then idle COM.
    doReset();
    for (int c = 0; c < 48; c++) begin
      vecs[c].valid = (c <= 31);
      vecs[c].data  = (c == 31) ? 8'hA5 : 8'h5A;
    end
    syms = '{COM, COM, COM, COM, 8'hA5, COM, COM, COM};
    fillExpect(48);
    runVectors("single", 48);

    // Back-to-back 00, FF, 3C with no gap between bytes.
    doReset();
    for (int c = 0; c < 64; c++) begin
      vecs[c].valid = (c <= 47);
      vecs[c].data  = (c <= 31) ? 8'h00 : (c <= 39) ? 8'hFF : 8'h3C;
    end
    syms = '{COM, COM, COM, COM, 8'h00, 8'hFF, 8'h3C, COM};
    fillExpect(64);
    runVectors("b2b", 64);

    // valid raised mid-symbol waits for the next ready; data_in changing
    // while the byte shifts has no effect, and the held valid then sends 00.
    doReset();
    for (int c = 0; c < 64; c++) begin
      vecs[c].valid = (c >= 34) && (c <= 47);
      vecs[c].data  = (c < 42) ? 8'h81 : 8'h00;
    end
    syms = '{COM, COM, COM, COM, COM, 8'h81, 8'h00, COM};
    fillExpect(64);
    runVectors("hshk", 64);

    // Reset dropped at cycle 35 while A5 is shifting.
    doReset();
    for (int c = 0; c < 48; c++) begin
      vecs[c].valid = (c <= 31);
      vecs[c].data  = (c == 31) ? 8'hA5 : 8'h5A;
    end
    syms = '{COM, COM, COM, COM, 8'hA5, COM, COM, COM};
    fillExpect(48);
    runVectors("midpre", 35);
    checkOutput("mid_dout_before",   35, data_out,   1'b0);
    checkOutput("mid_active_before", 35, active_out, 1'b1);
    #1;
    reset_L = 1'b0;
    #1;
    checkOutput("mid_dout_async",   35, data_out,   1'b1);
    checkOutput("mid_ready_async",  35, ready_out,  1'b0);
    checkOutput("mid_active_async", 35, active_out, 1'b0);
    doReset();
    for (int c = 0; c < 32; c++) begin
      vecs[c].valid = 1'b1;
      vecs[c].data  = 8'h77;
    end
    syms = '{COM, COM, COM, COM, COM, COM, COM, COM};
    fillExpect(32);
    runVectors("midpost", 32);

    applyStimulus(1'b0, 8'h00);
    @(posedge clk_8f);
    #1;
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
